// File: rtl/lsu_data_memory_pkg.sv
// Shared definitions for the load/store data memory: RV32I width codes,
// controller state encodings and the access-size decode.
package lsu_data_memory_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam int LANES = 4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WAIT   = 2'd1,
        ST_ACCESS = 2'd2,
        ST_RESP   = 2'd3
    } lsu_state_e;

    // Access size in bytes; 0 marks an illegal width code.
    function automatic logic [2:0] f3_size_bytes(input logic [2:0] f3);
        case (f3)
            F3_B, F3_BU: f3_size_bytes = 3'd1;
            F3_H, F3_HU: f3_size_bytes = 3'd2;
            F3_W:        f3_size_bytes = 3'd4;
            default:     f3_size_bytes = 3'd0;
        endcase
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational request checker, store lane-enable generator and load
// extraction/extension for the byte-addressed data memory.
module lsu_align
    import lsu_data_memory_pkg::*;
#(
    parameter int XLEN        = 32,
    parameter int DEPTH_BYTES = 1024
) (
    input  logic              write,
    input  logic [2:0]        funct3,
    input  logic [XLEN-1:0]   addr,
    input  logic [XLEN-1:0]   wdata,
    input  logic [8*LANES-1:0] rd_word,
    output logic              err,
    output logic [LANES-1:0]  byte_en,
    output logic [8*LANES-1:0] wr_data,
    output logic [XLEN-1:0]   rdata
);

    logic [2:0]      size;
    logic [XLEN:0]   last_byte;
    logic            misaligned;
    logic            out_of_range;
    logic            bad_f3;
    logic [XLEN-1:0] ext;

    always_comb begin
        size = f3_size_bytes(funct3);
        // One extra bit so addresses near the top of the space cannot wrap.
        last_byte    = {1'b0, addr} + (XLEN+1)'(size) - (XLEN+1)'(1);
        out_of_range = last_byte >= (XLEN+1)'(DEPTH_BYTES);
        misaligned   = ((size == 3'd2) && addr[0]) ||
                       ((size == 3'd4) && (addr[1:0] != 2'b00));
        bad_f3       = (size == 3'd0) ||
                       (write && ((funct3 == F3_BU) || (funct3 == F3_HU)));
        err          = bad_f3 || misaligned || out_of_range;
    end

    always_comb begin
        byte_en = '0;
        wr_data = '0;
        case (size)
            3'd1: begin byte_en = 4'b0001; wr_data = {24'd0, wdata[7:0]};  end
            3'd2: begin byte_en = 4'b0011; wr_data = {16'd0, wdata[15:0]}; end
            3'd4: begin byte_en = 4'b1111; wr_data = wdata[31:0];          end
            default: ;
        endcase
        if (err || !write) begin
            byte_en = '0;
        end
    end

    always_comb begin
        ext = '0;
        case (funct3)
            F3_B:  ext = {{(XLEN-8){rd_word[7]}}, rd_word[7:0]};
            F3_BU: ext = {{(XLEN-8){1'b0}}, rd_word[7:0]};
            F3_H:  ext = {{(XLEN-16){rd_word[15]}}, rd_word[15:0]};
            F3_HU: ext = {{(XLEN-16){1'b0}}, rd_word[15:0]};
            F3_W:  ext = XLEN'(rd_word);
            default: ext = '0;
        endcase
        rdata = (err || write) ? '0 : ext;
    end

endmodule

// File: rtl/lsu_data_memory.sv
// Byte-addressed little-endian data memory behind a request/response
// handshake with a programmable number of wait states.
module lsu_data_memory
  import lsu_data_memory_pkg::*;
#(
  parameter int    XLEN        = 32,
  parameter int    DEPTH_BYTES = 1024,
  parameter int    WAIT_STATES = 1,
  parameter string INIT_FILE   = ""
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_write,
  input  logic [XLEN-1:0] req_addr,
  input  logic [XLEN-1:0] req_wdata,
  input  logic [2:0]      req_funct3,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [XLEN-1:0] rsp_rdata,
  output logic            rsp_err
);

  localparam int AW = $clog2(DEPTH_BYTES);

  // Handshake: a request transfers on a clock edge where req_valid && req_ready;
  // a response transfers where rsp_valid && rsp_ready, and rsp_* hold until then.

  lsu_state_e      state_q, state_d;
  logic [3:0]      cnt_q, cnt_d;
  logic            write_q, write_d;
  logic [XLEN-1:0] addr_q, addr_d;
  logic [XLEN-1:0] wdata_q, wdata_d;
  logic [2:0]      funct3_q, funct3_d;
  logic [XLEN-1:0] rsp_rdata_q, rsp_rdata_d;
  logic            rsp_err_q, rsp_err_d;

  logic [7:0]          mem [DEPTH_BYTES];
  logic [AW-1:0]       idx;
  logic [8*LANES-1:0]  rd_word;
  logic                acc_err;
  logic [LANES-1:0]    byte_en;
  logic [8*LANES-1:0]  wr_data;
  logic [XLEN-1:0]     acc_rdata;

  assign idx = addr_q[AW-1:0];

  always_comb begin
    rd_word = '0;
    for (int i = 0; i < LANES; i++) begin
      rd_word[8*i +: 8] = mem[idx + AW'(i)];
    end
  end

  lsu_align #(
    .XLEN        (XLEN),
    .DEPTH_BYTES (DEPTH_BYTES)
  ) u_align (
    .write   (write_q),
    .funct3  (funct3_q),
    .addr    (addr_q),
    .wdata   (wdata_q),
    .rd_word (rd_word),
    .err     (acc_err),
    .byte_en (byte_en),
    .wr_data (wr_data),
    .rdata   (acc_rdata)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    write_d     = write_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    funct3_d    = funct3_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          write_d  = req_write;
          addr_d   = req_addr;
          wdata_d  = req_wdata;
          funct3_d = req_funct3;
          cnt_d    = '0;
          state_d  = (WAIT_STATES > 0) ? ST_WAIT : ST_ACCESS;
        end
      end
      ST_WAIT: begin
        cnt_d = cnt_q + 4'd1;
        if (({1'b0, cnt_q} + 5'd1) == 5'(WAIT_STATES)) begin
          cnt_d   = '0;
          state_d = ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        rsp_rdata_d = acc_rdata;
        rsp_err_d   = acc_err;
        state_d     = ST_RESP;
      end
      ST_RESP: begin
        if (rsp_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      write_q     <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      funct3_q    <= '0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      write_q     <= write_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      funct3_q    <= funct3_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  // Storage is not reset; the async reset forces IDLE, which blocks the write.
  always_ff @(posedge clk) begin
    if (state_q == ST_ACCESS) begin
      for (int i = 0; i < LANES; i++) begin
        if (byte_en[i]) begin
          mem[idx + AW'(i)] <= wr_data[8*i +: 8];
        end
      end
    end
  end

  assign req_ready = (state_q == ST_IDLE);
  assign rsp_valid = (state_q == ST_RESP);
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_lsu_data_memory.sv
// Bench for lsu_data_memory: three instances (0, 1 and 3 wait states) driven
// one at a time, responses checked against an expected queue.
module tb_lsu_data_memory;

    localparam int DEPTH = 1024;
    localparam logic [2:0] B = 3'b000, H = 3'b001, W = 3'b010, BU = 3'b100, HU = 3'b101;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid [3];
    logic        req_ready [3];
    logic        req_write [3];
    logic [31:0] req_addr  [3];
    logic [31:0] req_wdata [3];
    logic [2:0]  req_funct3[3];
    logic        rsp_valid [3];
    logic        rsp_ready [3];
    logic [31:0] rsp_rdata [3];
    logic        rsp_err   [3];

    logic [32:0] exp_q[$];
    logic [7:0]  model [DEPTH];
    int          n_vec  = 0;
    int          n_miss = 0;

    always #5 clk = ~clk;

    lsu_data_memory #(.WAIT_STATES(0)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
        .req_write(req_write[0]), .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
        .req_funct3(req_funct3[0]), .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]),
        .rsp_rdata(rsp_rdata[0]), .rsp_err(rsp_err[0]));

    lsu_data_memory #(.WAIT_STATES(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
        .req_write(req_write[1]), .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
        .req_funct3(req_funct3[1]), .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]),
        .rsp_rdata(rsp_rdata[1]), .rsp_err(rsp_err[1]));

    lsu_data_memory #(.WAIT_STATES(3)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid[2]), .req_ready(req_ready[2]),
        .req_write(req_write[2]), .req_addr(req_addr[2]), .req_wdata(req_wdata[2]),
        .req_funct3(req_funct3[2]), .rsp_valid(rsp_valid[2]), .rsp_ready(rsp_ready[2]),
        .rsp_rdata(rsp_rdata[2]), .rsp_err(rsp_err[2]));

    function automatic int ws_of(input int d);
        return (d == 0) ? 0 : ((d == 1) ? 1 : 3);
    endfunction

    task automatic check_eq(input string tag, input logic [32:0] act, input logic [32:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // Expected load result from the byte model: {err, rdata}.
    function automatic logic [32:0] model_load(input logic [2:0] f3, input logic [31:0] a);
        logic [31:0] w;
        w = {model[a+3], model[a+2], model[a+1], model[a]};
        case (f3)
            B:  return {1'b0, {24{w[7]}}, w[7:0]};
            BU: return {1'b0, 24'd0, w[7:0]};
            H:  return {1'b0, {16{w[15]}}, w[15:0]};
            HU: return {1'b0, 16'd0, w[15:0]};
            default: return {1'b0, w};
        endcase
    endfunction

    // Full transaction; hold > 0 keeps rsp_ready low that many cycles while a
    // stray store to 0x40 is offered and must be ignored.
    task automatic xact(input int d, input logic wr, input logic [31:0] a, input logic [31:0] wd,
                        input logic [2:0] f3, input logic [32:0] exp, input int hold);
        int lat;
        logic [32:0] e;
        exp_q.push_back(exp);
        @(negedge clk);
        req_valid[d] = 1'b1; req_write[d] = wr; req_addr[d] = a;
        req_wdata[d] = wd;   req_funct3[d] = f3;
        check_eq("req_ready_idle", {32'd0, req_ready[d]}, 33'd1);
        @(posedge clk);
        lat = 1;
        #1;
        req_valid[d] = 1'b0; req_write[d] = ~wr; req_addr[d] = $urandom;
        req_wdata[d] = $urandom; req_funct3[d] = 3'($urandom_range(0, 7));
        while (!rsp_valid[d] && lat < 40) begin
            @(posedge clk);
            lat++;
            #1;
        end
        check_eq("latency", 33'(lat), 33'(ws_of(d) + 2));
        e = exp_q.pop_front();
        check_eq("rsp", {rsp_err[d], rsp_rdata[d]}, e);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            req_valid[d] = 1'b1; req_write[d] = 1'b1; req_addr[d] = 32'h40;
            req_wdata[d] = 32'h1111_1111; req_funct3[d] = W;
            check_eq("hold_valid", {32'd0, rsp_valid[d]}, 33'd1);
            check_eq("hold_ready", {32'd0, req_ready[d]}, 33'd0);
            check_eq("hold_rsp", {rsp_err[d], rsp_rdata[d]}, e);
        end
        @(negedge clk);
        req_valid[d] = 1'b0;
        rsp_ready[d] = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready[d] = 1'b0;
        check_eq("back_idle", {31'd0, req_ready[d], rsp_valid[d]}, 33'b10);
    endtask

    initial begin
        logic [31:0] a, wd;
        logic [2:0]  f3;
        int          op;
        for (int i = 0; i < 3; i++) begin
            req_valid[i] = 1'b0; req_write[i] = 1'b0; req_addr[i] = '0;
            req_wdata[i] = '0;   req_funct3[i] = '0;  rsp_ready[i] = 1'b0;
        end
        rst_n = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
            check_eq("reset_outs", {29'd0, req_ready[i], rsp_valid[i], rsp_err[i], |rsp_rdata[i]},
                     33'b1000);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Word round trip and sub-word extension on every wait-state setting.
        for (int d = 0; d < 3; d++) begin
            xact(d, 1'b1, 32'h10, 32'hDEAD_BEEF, W,  33'h0_0000_0000, 0);
            xact(d, 1'b0, 32'h10, 32'h0,         W,  33'h0_DEAD_BEEF, 0);
            xact(d, 1'b0, 32'h13, 32'h0,         B,  33'h0_FFFF_FFDE, 0);
            xact(d, 1'b0, 32'h13, 32'h0,         BU, 33'h0_0000_00DE, 0);
            xact(d, 1'b0, 32'h10, 32'h0,         H,  33'h0_FFFF_BEEF, 0);
            xact(d, 1'b0, 32'h12, 32'h0,         HU, 33'h0_0000_DEAD, 0);
        end

        // Error cases and range boundaries.
        xact(1, 1'b1, 32'h11,        32'h1234,      H,      33'h1_0000_0000, 0);
        xact(1, 1'b0, 32'h10,        32'h0,         W,      33'h0_DEAD_BEEF, 0);
        xact(1, 1'b0, 32'h12,        32'h0,         W,      33'h1_0000_0000, 0);
        xact(1, 1'b1, DEPTH - 2,     32'h5555_5555, W,      33'h1_0000_0000, 0);
        xact(1, 1'b0, 32'h10,        32'h0,         3'b011, 33'h1_0000_0000, 0);
        xact(1, 1'b1, 32'h10,        32'h77,        BU,     33'h1_0000_0000, 0);
        xact(1, 1'b0, 32'hFFFF_FFFC, 32'h0,         W,      33'h1_0000_0000, 0);
        xact(1, 1'b1, DEPTH - 4,     32'h8765_4321, W,      33'h0_0000_0000, 0);
        xact(1, 1'b0, DEPTH - 1,     32'h0,         B,      33'h0_FFFF_FF87, 0);
        xact(1, 1'b0, DEPTH - 2,     32'h0,         HU,     33'h0_0000_8765, 0);
        xact(1, 1'b0, DEPTH - 1,     32'h0,         H,      33'h1_0000_0000, 0);
        xact(1, 1'b0, 32'h10,        32'h0,         W,      33'h0_DEAD_BEEF, 0);

        // Back-pressure on the response; the stray store must not land.
        xact(1, 1'b1, 32'h40, 32'hCAFE_F00D, W, 33'h0_0000_0000, 0);
        xact(1, 1'b0, 32'h40, 32'h0,         W, 33'h0_CAFE_F00D, 5);
        xact(1, 1'b0, 32'h40, 32'h0,         W, 33'h0_CAFE_F00D, 0);

        // Reset during the wait state drops the store and clears outputs.
        xact(1, 1'b1, 32'h20, 32'h1234_5678, W, 33'h0_0000_0000, 0);
        xact(1, 1'b0, 32'h20, 32'h0,         W, 33'h0_1234_5678, 0);
        @(negedge clk);
        req_valid[1] = 1'b1; req_write[1] = 1'b1; req_addr[1] = 32'h20;
        req_wdata[1] = 32'hA5A5_A5A5; req_funct3[1] = W;
        @(posedge clk);
        #1;
        req_valid[1] = 1'b0;
        check_eq("in_wait", {31'd0, req_ready[1], rsp_valid[1]}, 33'b00);
        rst_n = 1'b0;
        #1;
        check_eq("rst_ctrl", {31'd0, req_ready[1], rsp_valid[1]}, 33'b10);
        check_eq("rst_rsp", {rsp_err[1], rsp_rdata[1]}, 33'h0_0000_0000);
        @(negedge clk);
        rst_n = 1'b1;
        xact(1, 1'b0, 32'h20, 32'h0, W, 33'h0_1234_5678, 0);

        // Random mixed traffic against a byte model in 0x100..0x13F.
        for (int d = 1; d < 3; d++) begin
            for (int i = 0; i < 16; i++) begin
                wd = $urandom;
                a  = 32'h100 + 32'(4 * i);
                {model[a+3], model[a+2], model[a+1], model[a]} = wd;
                xact(d, 1'b1, a, wd, W, 33'h0_0000_0000, 0);
            end
            for (int i = 0; i < 30; i++) begin
                op = $urandom_range(0, 7);
                a  = 32'h100 + 32'($urandom_range(0, 63));
                wd = $urandom;
                case (op)
                    0, 5:    f3 = B;
                    1, 6:    f3 = H;
                    2:       f3 = W;
                    3:       f3 = BU;
                    default: f3 = HU;
                endcase
                if (f3 == H || f3 == HU) a[0] = 1'b0;
                if (f3 == W) a[1:0] = 2'b00;
                if (op < 3) begin
                    model[a] = wd[7:0];
                    if (f3 != B) model[a+1] = wd[15:8];
                    if (f3 == W) begin
                        model[a+2] = wd[23:16];
                        model[a+3] = wd[31:24];
                    end
                    xact(d, 1'b1, a, wd, f3, 33'h0_0000_0000, 0);
                end else begin
                    xact(d, 1'b0, a, 32'h0, f3, model_load(f3, a), 0);
                end
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
